// File: rtl/asteroids_pkg.sv
// Shared constants and state encoding for the asteroids video-side blocks.
package asteroids_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned BCD_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2,
    ST_SCORE  = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit saturating BCD incrementer with synchronous clear (clear wins).
module bcd_counter
  import asteroids_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [DIGITS*BCD_W-1:0]   value_o
);

  localparam int unsigned W = DIGITS * BCD_W;

  logic [W-1:0] value_q, value_d, incr_c;
  logic         all_nines_c, carry_c;

  // Ripple the +1 through the digits; all-nines holds the value.
  always_comb begin
    incr_c      = value_q;
    carry_c     = 1'b1;
    all_nines_c = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (value_q[d*BCD_W +: BCD_W] != BCD_W'(9)) begin
        all_nines_c = 1'b0;
      end
      if (carry_c) begin
        if (value_q[d*BCD_W +: BCD_W] >= BCD_W'(9)) begin
          incr_c[d*BCD_W +: BCD_W] = '0;
        end else begin
          incr_c[d*BCD_W +: BCD_W] = value_q[d*BCD_W +: BCD_W] + BCD_W'(1);
          carry_c                  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && !all_nines_c) begin
      value_d = incr_c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/collision_monitor.sv
// Samples sprite draw pixels against the VGA scan, reports per-object hits
// once per frame, and keeps the BCD score and sticky game-over flag.
module collision_monitor #(
  parameter int unsigned N_TORP   = 4,
  parameter int unsigned N_AST    = 8,
  parameter int unsigned H_ACTIVE = asteroids_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = asteroids_pkg::V_ACTIVE,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  iPClk,
  input  logic                  iRst,
  input  logic [10:0]           iVGA_X,
  input  logic [10:0]           iVGA_Y,
  input  logic [N_TORP-1:0]     iTorpDraw,
  input  logic [N_AST-1:0]      iAstDraw,
  input  logic                  iShipDraw,
  input  logic                  iClearScore,
  output logic [N_TORP-1:0]     oTorpHit,
  output logic [N_AST-1:0]      oAstHit,
  output logic                  oShipHit,
  output logic                  oFrameStart,
  output logic [4*DIGITS-1:0]   oScore,
  output logic                  oGameOver
);

  import asteroids_pkg::*;

  localparam int unsigned HC_W   = $clog2(N_AST + 1);
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

  function automatic logic [HC_W-1:0] popcount(input logic [N_AST-1:0] v);
    logic [HC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_AST; i++) begin
      c = c + HC_W'(v[i]);
    end
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [N_TORP-1:0]   torp_pend_q, torp_pend_d;
  logic [N_AST-1:0]    ast_pend_q, ast_pend_d;
  logic                ship_pend_q, ship_pend_d;
  logic [HC_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [N_TORP-1:0]   torp_hit_q, torp_hit_d;
  logic [N_AST-1:0]    ast_hit_q, ast_hit_d;
  logic                ship_hit_q, ship_hit_d;
  logic                frame_start_q, frame_start_d;
  logic                game_over_q, game_over_d;

  logic                sample_c, origin_c, last_c, score_inc_c;
  logic [N_TORP-1:0]   torp_ov_c;
  logic [N_AST-1:0]    ast_ov_c;
  logic                ship_ov_c;
  logic [HC_W-1:0]     ast_cnt_c;

  assign sample_c  = (iVGA_X < H_LIM) && (iVGA_Y < V_LIM);
  assign origin_c  = sample_c && (iVGA_X == 11'd0) && (iVGA_Y == 11'd0);
  assign last_c    = sample_c && (iVGA_X == H_LAST) && (iVGA_Y == V_LAST);

  // Ship/torpedo and same-class overlaps are deliberately not considered.
  assign torp_ov_c = iTorpDraw & {N_TORP{|iAstDraw}};
  assign ast_ov_c  = iAstDraw & {N_AST{|iTorpDraw}};
  assign ship_ov_c = iShipDraw & (|iAstDraw);
  assign ast_cnt_c = popcount(ast_pend_q);

  always_comb begin
    state_d       = state_q;
    torp_pend_d   = torp_pend_q;
    ast_pend_d    = ast_pend_q;
    ship_pend_d   = ship_pend_q;
    hit_cnt_d     = hit_cnt_q;
    torp_hit_d    = '0;
    ast_hit_d     = '0;
    ship_hit_d    = 1'b0;
    frame_start_d = 1'b0;
    game_over_d   = game_over_q;
    score_inc_c   = 1'b0;

    // A sample at the origin always (re)starts accumulation, aborting any frame.
    if (origin_c) begin
      state_d       = ST_ACCUM;
      torp_pend_d   = torp_ov_c;
      ast_pend_d    = ast_ov_c;
      ship_pend_d   = ship_ov_c;
      hit_cnt_d     = '0;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ACCUM: begin
          if (sample_c) begin
            torp_pend_d = torp_pend_q | torp_ov_c;
            ast_pend_d  = ast_pend_q | ast_ov_c;
            ship_pend_d = ship_pend_q | ship_ov_c;
            if (last_c) begin
              state_d    = ST_REPORT;
              torp_hit_d = torp_pend_d;
              ast_hit_d  = ast_pend_d;
              ship_hit_d = ship_pend_d;
            end
          end
        end
        ST_REPORT: begin
          hit_cnt_d   = ast_cnt_c;
          torp_pend_d = '0;
          ast_pend_d  = '0;
          ship_pend_d = 1'b0;
          if (ship_pend_q) begin
            game_over_d = 1'b1;
          end
          state_d = (ast_cnt_c != '0) ? ST_SCORE : ST_IDLE;
        end
        ST_SCORE: begin
          if (iClearScore) begin
            hit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            score_inc_c = 1'b1;
            hit_cnt_d   = hit_cnt_q - HC_W'(1);
            if (hit_cnt_q == HC_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (iClearScore) begin
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge iPClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= ST_IDLE;
      torp_pend_q   <= '0;
      ast_pend_q    <= '0;
      ship_pend_q   <= 1'b0;
      hit_cnt_q     <= '0;
      torp_hit_q    <= '0;
      ast_hit_q     <= '0;
      ship_hit_q    <= 1'b0;
      frame_start_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      torp_pend_q   <= torp_pend_d;
      ast_pend_q    <= ast_pend_d;
      ship_pend_q   <= ship_pend_d;
      hit_cnt_q     <= hit_cnt_d;
      torp_hit_q    <= torp_hit_d;
      ast_hit_q     <= ast_hit_d;
      ship_hit_q    <= ship_hit_d;
      frame_start_q <= frame_start_d;
      game_over_q   <= game_over_d;
    end
  end

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk_i   (iPClk),
    .rst_i   (iRst),
    .clr_i   (iClearScore),
    .inc_i   (score_inc_c),
    .value_o (oScore)
  );

  assign oTorpHit    = torp_hit_q;
  assign oAstHit     = ast_hit_q;
  assign oShipHit    = ship_hit_q;
  assign oFrameStart = frame_start_q;
  assign oGameOver   = game_over_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Frame-level bench for collision_monitor: compressed scans (origin, a few
// pixels, last pixel) checked against an integer score / hit-set model.
module tb_collision_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vga_x = 11'd640;
  logic [10:0] vga_y = 11'd0;
  logic [3:0]  torp_draw = '0;
  logic [7:0]  ast_draw = '0;
  logic        ship_draw = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  torp_hit;
  logic [7:0]  ast_hit;
  logic        ship_hit;
  logic        frame_start;
  logic [15:0] score;
  logic        game_over;

  collision_monitor dut (
    .iPClk       (clk),
    .iRst        (rst),
    .iVGA_X      (vga_x),
    .iVGA_Y      (vga_y),
    .iTorpDraw   (torp_draw),
    .iAstDraw    (ast_draw),
    .iShipDraw   (ship_draw),
    .iClearScore (clr),
    .oTorpHit    (torp_hit),
    .oAstHit     (ast_hit),
    .oShipHit    (ship_hit),
    .oFrameStart (frame_start),
    .oScore      (score),
    .oGameOver   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  t;
    logic [7:0]  a;
    logic        s;
  } pix_t;

  typedef struct {
    logic [3:0] t;
    logic [7:0] a;
    logic       s;
    logic [3:0] et;
    logic [7:0] ea;
    logic       es;
  } vec_t;

  pix_t       fq[$];
  vec_t       tbl[7];
  int         n_vec = 0;
  int         n_err = 0;
  int         m_score = 0;
  logic       m_go = 1'b0;
  logic [3:0] got_t;
  logic [7:0] got_a;
  logic       got_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          q;
    q = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  // One clock: drive at negedge, outputs observed at the following negedge.
  task automatic cyc(input logic [10:0] x, input logic [10:0] y, input logic [3:0] t,
                     input logic [7:0] a, input logic s, input logic c);
    vga_x = x; vga_y = y; torp_draw = t; ast_draw = a; ship_draw = s; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(11'd640, 11'd0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic play_frame(input string nm, input int idle_n);
    logic [3:0] et;
    logic [7:0] ea;
    logic       es;
    et = '0; ea = '0; es = 1'b0;
    cyc(11'd0, 11'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    chk({nm, " frame_start"}, 32'(frame_start), 32'd1);
    foreach (fq[i]) begin
      cyc(fq[i].x, fq[i].y, fq[i].t, fq[i].a, fq[i].s, 1'b0);
      if (i == 0) chk({nm, " frame_start_pulse"}, 32'(frame_start), 32'd0);
      if (fq[i].x < 11'd640 && fq[i].y < 11'd480) begin
        if (fq[i].a != 8'd0) et |= fq[i].t;
        if (fq[i].t != 4'd0) ea |= fq[i].a;
        if (fq[i].s && fq[i].a != 8'd0) es = 1'b1;
      end
    end
    cyc(11'd639, 11'd479, 4'd0, 8'd0, 1'b0, 1'b0);
    got_t = torp_hit; got_a = ast_hit; got_s = ship_hit;
    chk({nm, " torp_hit"}, 32'(got_t), 32'(et));
    chk({nm, " ast_hit"}, 32'(got_a), 32'(ea));
    chk({nm, " ship_hit"}, 32'(got_s), 32'(es));
    m_score = m_score + $countones(ea);
    if (m_score > 9999) m_score = 9999;
    m_go = m_go | es;
    fq.delete();
    if (idle_n > 0) begin
      idle();
      chk({nm, " hits_single_cycle"}, 32'({torp_hit, ast_hit, ship_hit}), 32'd0);
      repeat (idle_n - 1) idle();
      chk({nm, " score"}, 32'(score), 32'(to_bcd(m_score)));
      chk({nm, " game_over"}, 32'(game_over), 32'(m_go));
    end
  endtask

  task automatic hits_frame(input int k);
    fq.push_back('{11'd300, 11'd100, 4'b0001, 8'((1 << k) - 1), 1'b0});
    play_frame("hits", 10);
  endtask

  task automatic clear_score(input string nm);
    cyc(11'd640, 11'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    m_score = 0; m_go = 1'b0;
    chk({nm, " score"}, 32'(score), 32'd0);
    chk({nm, " game_over"}, 32'(game_over), 32'd0);
    idle();
  endtask

  initial begin
    int   base;
    pix_t p;

    tbl[0] = '{4'b0001, 8'h00, 1'b0, 4'b0000, 8'h00, 1'b0};
    tbl[1] = '{4'b0010, 8'h20, 1'b0, 4'b0010, 8'h20, 1'b0};
    tbl[2] = '{4'b0000, 8'h03, 1'b0, 4'b0000, 8'h00, 1'b0};
    tbl[3] = '{4'b1100, 8'h00, 1'b1, 4'b0000, 8'h00, 1'b0};
    tbl[4] = '{4'b0100, 8'h10, 1'b1, 4'b0100, 8'h10, 1'b1};
    tbl[5] = '{4'b1111, 8'h81, 1'b0, 4'b1111, 8'h81, 1'b0};
    tbl[6] = '{4'b0000, 8'h08, 1'b1, 4'b0000, 8'h00, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", 32'({torp_hit, ast_hit, ship_hit, frame_start, game_over}), 32'd0);
    chk("reset score", 32'(score), 32'd0);
    rst = 1'b0;
    idle();

    // Torpedo and asteroid drawn at different pixels
    fq.push_back('{11'd100, 11'd100, 4'b0001, 8'h00, 1'b0});
    fq.push_back('{11'd200, 11'd200, 4'b0000, 8'h08, 1'b0});
    play_frame("no_overlap", 10);

    // Single overlap, then a clean frame must not repeat the pulse
    fq.push_back('{11'd320, 11'd200, 4'b0010, 8'h20, 1'b0});
    play_frame("t1_a5", 10);
    chk("t1_a5 torp_const", 32'(got_t), 32'h2);
    chk("t1_a5 ast_const", 32'(got_a), 32'h20);
    play_frame("after_t1_a5", 10);

    // Two asteroids struck by torpedo 0, score steps once per cycle
    base = m_score;
    fq.push_back('{11'd10, 11'd10, 4'b0001, 8'h04, 1'b0});
    fq.push_back('{11'd20, 11'd20, 4'b0001, 8'h40, 1'b0});
    play_frame("two_ast", 0);
    chk("two_ast torp_const", 32'(got_t), 32'h1);
    chk("two_ast ast_const", 32'(got_a), 32'h44);
    idle();
    chk("two_ast score_report", 32'(score), 32'(to_bcd(base)));
    idle();
    chk("two_ast score_step1", 32'(score), 32'(to_bcd(base + 1)));
    idle();
    chk("two_ast score_step2", 32'(score), 32'(to_bcd(base + 2)));
    repeat (8) idle();

    // Ship struck by asteroid; ship/torpedo overlap ignored; sticky game over
    fq.push_back('{11'd320, 11'd240, 4'b0000, 8'h01, 1'b1});
    fq.push_back('{11'd50, 11'd50, 4'b0001, 8'h00, 1'b1});
    play_frame("ship", 10);
    chk("ship ship_const", 32'(got_s), 32'd1);
    chk("ship torp_const", 32'(got_t), 32'd0);
    play_frame("ship_sticky", 10);
    chk("ship sticky_const", 32'(game_over), 32'd1);
    clear_score("ship_clear");

    // Table of single-pixel overlap patterns at (300,150)
    for (int i = 0; i < 7; i++) begin
      fq.push_back('{11'd300, 11'd150, tbl[i].t, tbl[i].a, tbl[i].s});
      play_frame($sformatf("tbl%0d", i), 10);
      chk($sformatf("tbl%0d torp_const", i), 32'(got_t), 32'(tbl[i].et));
      chk($sformatf("tbl%0d ast_const", i), 32'(got_a), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d ship_const", i), 32'(got_s), 32'(tbl[i].es));
    end

    // Reset mid-ACCUM after an overlap at row 100
    cyc(11'd0, 11'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    cyc(11'd320, 11'd100, 4'b0001, 8'h01, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst outputs", 32'({torp_hit, ast_hit, ship_hit, frame_start, game_over}), 32'd0);
    chk("midrst score", 32'(score), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_score = 0; m_go = 1'b0;
    cyc(11'd639, 11'd479, 4'd0, 8'd0, 1'b0, 1'b0);
    chk("midrst no_report", 32'({torp_hit, ast_hit, ship_hit}), 32'd0);
    chk("midrst no_frame_start", 32'(frame_start), 32'd0);
    idle();
    play_frame("after_rst", 10);

    // Clear during SCORE drops the remaining increments
    base = m_score;
    fq.push_back('{11'd400, 11'd300, 4'b0001, 8'h0F, 1'b0});
    play_frame("clr_score", 0);
    idle();
    idle();
    chk("clr_score step1", 32'(score), 32'(to_bcd(base + 1)));
    cyc(11'd640, 11'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    chk("clr_score cleared", 32'(score), 32'd0);
    repeat (6) idle();
    chk("clr_score dropped", 32'(score), 32'd0);
    m_score = 0; m_go = 1'b0;

    // Carry chain 0099 -> 0100
    while (m_score + 8 <= 99) hits_frame(8);
    if (m_score < 99) hits_frame(99 - m_score);
    chk("carry at_0099", 32'(score), 32'h0099);
    hits_frame(1);
    chk("carry to_0100", 32'(score), 32'h0100);

    // Saturation at 9999
    while (m_score + 8 <= 9998) hits_frame(8);
    if (m_score < 9998) hits_frame(9998 - m_score);
    chk("sat at_9998", 32'(score), 32'h9998);
    hits_frame(3);
    chk("sat 9999", 32'(score), 32'h9999);
    hits_frame(1);
    chk("sat hold", 32'(score), 32'h9999);

    // Randomized frames against the frame-level model
    clear_score("rand_clear");
    for (int f = 0; f < 40; f++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        p.x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(640, 1023))
                                          : 11'($urandom_range(1, 638));
        p.y = 11'($urandom_range(0, 478));
        p.t = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
        p.a = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'd0;
        p.s = ($urandom_range(0, 3) == 0);
        fq.push_back(p);
      end
      play_frame($sformatf("rand%0d", f), 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
